// File: rtl/nn_status_monitor.sv
// Result tracker for Neural_Network outputs: yes/no/total counts, progress bar, sticky train flags, optional window.
// Latency: one cycle from an accepted result/flag pulse to every (registered) output.
// Backpressure: none; one result per cycle is accepted until total saturates, after which results are dropped.
//
// Ports: clk, reset (async, active-high), clear (sync, same values as reset),
//        start_train/end_system (flag pulses), result_valid/result_match (result strobe),
//        yes_cnt/no_cnt/total_cnt/saturated, progress, status_n[1:0] (active-low),
//        win_hits/win_full (sliding accuracy window).
// Build option: define NN_ACC_WINDOW_EN to implement the sliding window; otherwise
//        win_hits and win_full are tied to 0.
module nn_status_monitor #(
    parameter int CNT_BITS  = 14,
    parameter int NLED      = 4,
    parameter int STEP      = 10,
    parameter int WIN_DEPTH = 64,
    parameter int WIN_BITS  = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                start_train,
    input  logic                end_system,
    input  logic                result_valid,
    input  logic                result_match,
    output logic [CNT_BITS-1:0] yes_cnt,
    output logic [CNT_BITS-1:0] no_cnt,
    output logic [CNT_BITS-1:0] total_cnt,
    output logic                saturated,
    output logic [NLED-1:0]     progress,
    output logic [1:0]          status_n,
    output logic [WIN_BITS:0]   win_hits,
    output logic                win_full
);

    // STEP = 1 still needs a 1-bit step counter; it simply stays at 0.
    localparam int STEP_W = (STEP > 1) ? $clog2(STEP) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP - 1);

    logic                accept;
    logic [CNT_BITS-1:0] total_nxt;
    logic [STEP_W-1:0]   step_cnt;

    assign accept    = result_valid & ~clear & ~saturated;
    assign total_nxt = total_cnt + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            yes_cnt   <= '0;
            no_cnt    <= '0;
            total_cnt <= '0;
            saturated <= 1'b0;
            progress  <= '0;
            step_cnt  <= '0;
            status_n  <= 2'b11;
        end else if (clear) begin
            yes_cnt   <= '0;
            no_cnt    <= '0;
            total_cnt <= '0;
            saturated <= 1'b0;
            progress  <= '0;
            step_cnt  <= '0;
            status_n  <= 2'b11;
        end else begin
            if (start_train) status_n[0] <= 1'b0;
            if (end_system)  status_n[1] <= 1'b0;
            if (accept) begin
                if (result_match) yes_cnt <= yes_cnt + 1'b1;
                else              no_cnt  <= no_cnt + 1'b1;
                total_cnt <= total_nxt;
                // yes/no can never exceed total, so only total needs a saturation guard.
                if (total_nxt == '1) saturated <= 1'b1;
                if (step_cnt == STEP_LAST) begin
                    step_cnt <= '0;
                    if (progress != '1) progress <= progress + 1'b1;
                end else begin
                    step_cnt <= step_cnt + 1'b1;
                end
            end
        end
    end

`ifdef NN_ACC_WINDOW_EN
    logic [WIN_DEPTH-1:0] win_buf;
    logic [WIN_BITS-1:0]  wp;
    logic [WIN_BITS:0]    fill_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_buf  <= '0;
            wp       <= '0;
            fill_cnt <= '0;
            win_hits <= '0;
            win_full <= 1'b0;
        end else if (clear) begin
            win_buf  <= '0;
            wp       <= '0;
            fill_cnt <= '0;
            win_hits <= '0;
            win_full <= 1'b0;
        end else if (accept) begin
            win_buf[wp] <= result_match;
            wp          <= wp + 1'b1;
            if (!win_full) begin
                fill_cnt <= fill_cnt + 1'b1;
                if (fill_cnt == (WIN_BITS+1)'(WIN_DEPTH - 1)) win_full <= 1'b1;
                if (result_match) win_hits <= win_hits + 1'b1;
            end else if (result_match != win_buf[wp]) begin
                // Full window: net change is match - evicted, i.e. +1, -1 or 0.
                win_hits <= result_match ? win_hits + 1'b1 : win_hits - 1'b1;
            end
        end
    end
`else
    assign win_hits = '0;
    assign win_full = 1'b0;
`endif

endmodule
